count_display_monitor: RTL

- Receiving end of the decade-counter output interface.
- Synchronises the 4-bit BCD count and the wrap/beep strobe into the CLK domain, then:
  - registers the digit and drives a 7-segment display;
  - checks that the received digits follow the legal 0..9 sequence;
  - turns each wrap strobe into a timed square-wave tone burst for a passive buzzer.
- Sits on the display/buzzer board side, after the counter.

---
 rtl/count_display_monitor.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/count_display_monitor.sv
// Display/buzzer side of the decade counter: synchronises the BCD count and wrap strobe,
// drives a 7-segment digit, checks the digit sequence and plays a tone burst on each wrap.
// Optional macro COUNT_DISPLAY_ERRCNT_EN enables the saturating err_cnt register (tied to 0 otherwise).
//
// Handshake: there is no valid/ready pair; cnt_in and wrap_in are free-running levels sampled
// through synchronisers, and every output is a registered level or one-cycle pulse in the CLK domain.
module count_display_monitor #(
    parameter int TONE_HALF   = 12500,
    parameter int BEEP_CYCLES = 12500000
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic [3:0] cnt_in,
    input  logic       wrap_in,
    output logic [3:0] digit_q,
    output logic [6:0] seg,
    output logic       seq_err,
    output logic [7:0] err_cnt,
    output logic       tone,
    output logic       beep_busy,
    output logic       o_dbg_chk_state,
    output logic       o_dbg_beep_state
);

    localparam int HW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int BW = $clog2(BEEP_CYCLES);
    localparam logic [HW-1:0] HALF_LAST  = HW'(TONE_HALF - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BEEP_CYCLES - 1);

    typedef enum logic {CHK_INIT, CHK_TRACK} chk_state_t;
    typedef enum logic {BEEP_IDLE, BEEP_BURST} beep_state_t;

    chk_state_t  r_chk_state;
    beep_state_t r_beep_state;

    logic [3:0]    r_s1, r_s2, r_s3;
    logic          r_w1, r_w2, r_w3;
    logic [3:0]    r_digit;
    logic [6:0]    r_seg;
    logic          r_seq_err;
    logic          r_tone;
    logic          r_busy;
    logic [HW-1:0] r_half;
    logic [BW-1:0] r_burst;

    logic       w_accept;
    logic [3:0] w_expected;
    logic       w_legal;
    logic       w_err;
    logic       w_wrap_rise;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;
        endcase
    endfunction

    // A digit is taken only once it has been seen on two consecutive samples, which rejects
    // single-cycle glitches on the asynchronous bus.
    assign w_accept    = (r_s2 == r_s3) && ((r_chk_state == CHK_INIT) || (r_s2 != r_digit));
    assign w_expected  = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
    assign w_legal     = (r_s2 <= 4'd9) && ((r_s2 == w_expected) || (r_s2 == 4'd0));
    assign w_err       = w_accept && (r_chk_state == CHK_TRACK) && !w_legal;
    assign w_wrap_rise = r_w2 && !r_w3;

    always_ff @(posedge CLK) begin
        if (!rst) begin
            r_s1 <= 4'd0;
            r_s2 <= 4'd0;
            r_s3 <= 4'd0;
            r_w1 <= 1'b0;
            r_w2 <= 1'b0;
            r_w3 <= 1'b0;
        end else begin
            r_s1 <= cnt_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_w1 <= wrap_in;
            r_w2 <= r_w1;
            r_w3 <= r_w2;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            r_chk_state <= CHK_INIT;
            r_digit     <= 4'd0;
            r_seg       <= 7'h00;
            r_seq_err   <= 1'b0;
        end else begin
            r_seg     <= (r_chk_state == CHK_INIT) ? 7'h00 : seg_decode(r_digit);
            r_seq_err <= w_err;
            if (w_accept) begin
                r_digit     <= r_s2;
                r_chk_state <= CHK_TRACK;
            end
        end
    end

`ifdef COUNT_DISPLAY_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge CLK) begin
        if (!rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'h00;
`endif

    // A retrigger reloads the burst length but leaves the tone phase running.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            r_beep_state <= BEEP_IDLE;
            r_tone       <= 1'b0;
            r_busy       <= 1'b0;
            r_half       <= '0;
            r_burst      <= '0;
        end else begin
            case (r_beep_state)
                BEEP_IDLE: begin
                    if (w_wrap_rise) begin
                        r_beep_state <= BEEP_BURST;
                        r_tone       <= 1'b1;
                        r_busy       <= 1'b1;
                        r_half       <= '0;
                        r_burst      <= BURST_LAST;
                    end
                end
                BEEP_BURST: begin
                    if (r_half == HALF_LAST) begin
                        r_tone <= ~r_tone;
                        r_half <= '0;
                    end else begin
                        r_half <= r_half + HW'(1);
                    end
                    if (w_wrap_rise) begin
                        r_burst <= BURST_LAST;
                    end else if (r_burst == '0) begin
                        r_beep_state <= BEEP_IDLE;
                        r_tone       <= 1'b0;
                        r_busy       <= 1'b0;
                    end else begin
                        r_burst <= r_burst - BW'(1);
                    end
                end
                default: r_beep_state <= BEEP_IDLE;
            endcase
        end
    end

    assign digit_q          = r_digit;
    assign seg              = r_seg;
    assign seq_err          = r_seq_err;
    assign tone             = r_tone;
    assign beep_busy        = r_busy;
    assign o_dbg_chk_state  = (r_chk_state == CHK_TRACK);
    assign o_dbg_beep_state = (r_beep_state == BEEP_BURST);

endmodule
